// File: rtl/traduccion_pkg.sv
// Purpose: shared types and key map for the scanned keypad translator.
// Latency: n/a (types, constants and a pure lookup function).
// Backpressure: n/a.
package traduccion_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } estado_t;

    localparam logic [3:0] KEY_STAR = 4'hE;
    localparam logic [3:0] KEY_HASH = 4'hF;
    localparam logic [3:0] KEY_EQ   = 4'hD;

    localparam int MAP_SIZE = 16;

    // Row-major 4x4 layout: 1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # =
    localparam logic [3:0] KEY_MAP [MAP_SIZE] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        KEY_STAR, 4'h0, KEY_HASH, KEY_EQ
    };

    function automatic logic [3:0] map_key(input logic [3:0] idx);
        return KEY_MAP[idx];
    endfunction

endpackage

// File: rtl/sincronizador_2ff.sv
// Purpose: two-flop synchroniser for asynchronous level inputs.
// Latency: 2 clk cycles from input change to output.
// Backpressure: none; samples every cycle.
module sincronizador_2ff #(
    parameter int              WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // First stage absorbs metastability, second stage feeds the core.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/traduccion_teclado_scan.sv
// Purpose: scans a ROWS x COLS keypad, debounces, rejects ghosts and emits translated key events.
// Latency: key_valid one cycle after the end of the DEBOUNCE_SCANS-th matching full scan.
// Backpressure: none; key_valid is a single-cycle pulse the consumer must take when it appears.
module traduccion_teclado_scan
    import traduccion_pkg::*;
#(
    parameter int ROWS           = 4,
    parameter int COLS           = 4,
    parameter int CODE_W         = 4,
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 3,
    parameter int REPEAT_EN      = 0,
    parameter int REPEAT_DELAY   = 20,
    parameter int REPEAT_RATE    = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ROWS-1:0]   filas_n,
    output logic [COLS-1:0]   columnas_n,
    output logic [CODE_W-1:0] key_code,
    output logic              key_valid,
    output logic              key_held,
    output logic              multi_key
);

    localparam int IDX_W = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1;
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W = 16;

    localparam logic [CNT_W-1:0] DEB_L   = CNT_W'(DEBOUNCE_SCANS);
    localparam logic [CNT_W-1:0] DELAY_L = CNT_W'(REPEAT_DELAY);
    localparam logic [CNT_W-1:0] RATE_L  = CNT_W'(REPEAT_RATE);

    // Indices inside the 4x4 table use it; anything beyond keeps its own low bits.
    function automatic logic [CODE_W-1:0] traducir(input logic [IDX_W-1:0] idx);
        logic [31:0] ext;
        ext = 32'(idx);
        if (ext < 32'(MAP_SIZE)) begin
            return CODE_W'(map_key(ext[3:0]));
        end else begin
            return ext[CODE_W-1:0];
        end
    endfunction

    // ---------------------------------------------------------------
    // Column strobing
    // ---------------------------------------------------------------
    logic             scan_on;
    logic [COL_W-1:0] col;
    logic [COL_W-1:0] col_nxt;
    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] div_nxt;
    logic [COLS-1:0]  columnas_nxt;
    logic             div_last;
    logic             col_last;
    logic             sample;
    logic             scan_end;

    assign div_last = (div == DIV_W'(SCAN_DIV - 1));
    assign col_last = (col == COL_W'(COLS - 1));
    assign sample   = scan_on && div_last;
    assign scan_end = sample && col_last;

    // Next dwell position; scanning starts on column 0 right after reset.
    always_comb begin
        col_nxt      = col;
        div_nxt      = div;
        columnas_nxt = '1;
        if (!scan_on) begin
            col_nxt = '0;
            div_nxt = '0;
        end else if (div_last) begin
            div_nxt = '0;
            col_nxt = col_last ? '0 : col + COL_W'(1);
        end else begin
            div_nxt = div + DIV_W'(1);
        end
        columnas_nxt[col_nxt] = 1'b0;
    end

    // Strobe register: pins come straight from flops so they never glitch.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scan_on    <= 1'b0;
            col        <= '0;
            div        <= '0;
            columnas_n <= '1;
        end else begin
            scan_on    <= 1'b1;
            col        <= col_nxt;
            div        <= div_nxt;
            columnas_n <= columnas_nxt;
        end
    end

    // ---------------------------------------------------------------
    // Row capture and per-scan key count
    // ---------------------------------------------------------------
    logic [ROWS-1:0]  filas_sinc;
    logic [1:0]       col_hits;
    logic [ROW_W-1:0] col_row;
    logic [IDX_W-1:0] hit_idx;
    logic [1:0]       acc_cnt;
    logic [IDX_W-1:0] acc_idx;
    logic [2:0]       suma;
    logic [1:0]       tot_cnt;
    logic [IDX_W-1:0] tot_idx;

    sincronizador_2ff #(
        .WIDTH     (ROWS),
        .RESET_VAL ({ROWS{1'b1}})
    ) u_sinc_filas (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (filas_n),
        .q     (filas_sinc)
    );

    // Keys seen in the current column; counts saturate at 2 (= "more than one").
    always_comb begin
        col_hits = '0;
        col_row  = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (!filas_sinc[r]) begin
                if (col_hits == 2'd0) begin
                    col_row = ROW_W'(r);
                end
                if (col_hits != 2'd2) begin
                    col_hits = col_hits + 2'd1;
                end
            end
        end
        hit_idx = IDX_W'(int'(col_row) * COLS + int'(col));
    end

    // Running totals for the scan including the column being sampled now.
    always_comb begin
        suma    = {1'b0, acc_cnt} + {1'b0, col_hits};
        tot_cnt = (suma >= 3'd2) ? 2'd2 : suma[1:0];
        tot_idx = (acc_cnt == 2'd0) ? hit_idx : acc_idx;
    end

    // Accumulate over the columns of one scan; cleared at the wrap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_cnt <= '0;
            acc_idx <= '0;
        end else if (sample) begin
            if (col_last) begin
                acc_cnt <= '0;
                acc_idx <= '0;
            end else begin
                acc_cnt <= tot_cnt;
                acc_idx <= tot_idx;
            end
        end
    end

    // ---------------------------------------------------------------
    // Debounce / hold / release FSM, evaluated once per full scan
    // ---------------------------------------------------------------
    estado_t          state;
    estado_t          state_nxt;
    logic [IDX_W-1:0] cand;
    logic [IDX_W-1:0] cand_nxt;
    logic [CNT_W-1:0] deb_cnt;
    logic [CNT_W-1:0] deb_nxt;
    logic [CNT_W-1:0] rel_cnt;
    logic [CNT_W-1:0] rel_nxt;
    logic [CNT_W-1:0] rep_cnt;
    logic [CNT_W-1:0] rep_nxt;
    logic             rep_fase;
    logic             fase_nxt;
    logic [CODE_W-1:0] code_nxt;
    logic             valid_nxt;
    logic             held_nxt;
    logic             multi_nxt;
    logic             misma;

    // Scan verdict drives transitions; a multi-key scan freezes all counters.
    always_comb begin
        state_nxt = state;
        cand_nxt  = cand;
        deb_nxt   = deb_cnt;
        rel_nxt   = rel_cnt;
        rep_nxt   = rep_cnt;
        fase_nxt  = rep_fase;
        code_nxt  = key_code;
        valid_nxt = 1'b0;
        held_nxt  = key_held;
        multi_nxt = 1'b0;
        misma     = (tot_cnt == 2'd1) && (tot_idx == cand);
        if (scan_end) begin
            if (tot_cnt == 2'd2) begin
                multi_nxt = 1'b1;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (tot_cnt == 2'd1) begin
                            state_nxt = DEBOUNCE;
                            cand_nxt  = tot_idx;
                            deb_nxt   = CNT_W'(1);
                        end
                    end
                    DEBOUNCE: begin
                        if (tot_cnt == 2'd0) begin
                            state_nxt = IDLE;
                            deb_nxt   = '0;
                        end else if (misma) begin
                            deb_nxt = deb_cnt + CNT_W'(1);
                        end else begin
                            cand_nxt = tot_idx;
                            deb_nxt  = CNT_W'(1);
                        end
                    end
                    HELD: begin
                        if (misma) begin
                            if (REPEAT_EN != 0) begin
                                rep_nxt = rep_cnt + CNT_W'(1);
                                if (rep_nxt >= (rep_fase ? RATE_L : DELAY_L)) begin
                                    valid_nxt = 1'b1;
                                    rep_nxt   = '0;
                                    fase_nxt  = 1'b1;
                                end
                            end
                        end else begin
                            state_nxt = RELEASE;
                            rel_nxt   = CNT_W'(1);
                            rep_nxt   = '0;
                            fase_nxt  = 1'b0;
                        end
                    end
                    RELEASE: begin
                        if (tot_cnt == 2'd0) begin
                            rel_nxt = rel_cnt + CNT_W'(1);
                        end else if (misma) begin
                            state_nxt = HELD;
                            rel_nxt   = '0;
                        end else begin
                            state_nxt = DEBOUNCE;
                            cand_nxt  = tot_idx;
                            deb_nxt   = CNT_W'(1);
                            held_nxt  = 1'b0;
                            rel_nxt   = '0;
                        end
                    end
                    default: state_nxt = IDLE;
                endcase
                // Release confirmed once enough non-matching scans were seen.
                if (state_nxt == RELEASE && rel_nxt >= DEB_L) begin
                    state_nxt = IDLE;
                    held_nxt  = 1'b0;
                    rel_nxt   = '0;
                end
                // Press confirmed: latch the code and fire the event.
                if (state_nxt == DEBOUNCE && deb_nxt >= DEB_L) begin
                    state_nxt = HELD;
                    deb_nxt   = '0;
                    code_nxt  = traducir(cand_nxt);
                    valid_nxt = 1'b1;
                    held_nxt  = 1'b1;
                    rep_nxt   = '0;
                    fase_nxt  = 1'b0;
                end
            end
        end
    end

    // FSM state and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cand      <= '0;
            deb_cnt   <= '0;
            rel_cnt   <= '0;
            rep_cnt   <= '0;
            rep_fase  <= 1'b0;
            key_code  <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
            multi_key <= 1'b0;
        end else begin
            state     <= state_nxt;
            cand      <= cand_nxt;
            deb_cnt   <= deb_nxt;
            rel_cnt   <= rel_nxt;
            rep_cnt   <= rep_nxt;
            rep_fase  <= fase_nxt;
            key_code  <= code_nxt;
            key_valid <= valid_nxt;
            key_held  <= held_nxt;
            multi_key <= multi_nxt;
        end
    end

endmodule

// File: tb/tb_traduccion_teclado_scan.sv
// Purpose: self-checking bench for the scanned keypad translator (plain and auto-repeat builds).
// Latency: scan period is 16 cycles here; events land 1 cycle after a scan ends.
// Backpressure: n/a.
module tb_traduccion_teclado_scan;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [15:0] teclas = '0;

    logic [3:0] filas_a, filas_b, col_a, col_b, code_a, code_b;
    logic       valid_a, valid_b, held_a, held_b, multi_a, multi_b;

    int n_cmp = 0;
    int n_err = 0;
    int ecount;

    always #5 clk = ~clk;

    // Edge counter since reset release; ecount%16==0 marks the last cycle of a scan.
    always @(posedge clk) begin
        if (!rst_n) ecount <= 0;
        else        ecount <= ecount + 1;
    end

    traduccion_teclado_scan #(
        .ROWS(4), .COLS(4), .CODE_W(4), .SCAN_DIV(4), .DEBOUNCE_SCANS(3),
        .REPEAT_EN(0), .REPEAT_DELAY(4), .REPEAT_RATE(2)
    ) u_dut (
        .clk(clk), .rst_n(rst_n), .filas_n(filas_a), .columnas_n(col_a),
        .key_code(code_a), .key_valid(valid_a), .key_held(held_a), .multi_key(multi_a)
    );

    traduccion_teclado_scan #(
        .ROWS(4), .COLS(4), .CODE_W(4), .SCAN_DIV(4), .DEBOUNCE_SCANS(3),
        .REPEAT_EN(1), .REPEAT_DELAY(4), .REPEAT_RATE(2)
    ) u_rep (
        .clk(clk), .rst_n(rst_n), .filas_n(filas_b), .columnas_n(col_b),
        .key_code(code_b), .key_valid(valid_b), .key_held(held_b), .multi_key(multi_b)
    );

    // Keypad model: a pressed key pulls its row low while its column is strobed.
    always_comb begin
        filas_a = '1;
        filas_b = '1;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (teclas[r*4+c] && !col_a[c]) filas_a[r] = 1'b0;
                if (teclas[r*4+c] && !col_b[c]) filas_b[r] = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_boundary();
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while ((ecount % 16) != 0 && k < 40);
    endtask

    typedef struct {
        logic [15:0] teclas;
        int          scans;
        int          n_valid;
        logic [3:0]  code;
        int          n_multi;
    } vec_t;

    vec_t tabla [11];

    initial begin
        int cv_a, cv_b, cm;
        logic [3:0] col_exp;

        // bit index = row*4 + col
        tabla[0]  = '{16'h0001, 4, 1, 4'h1, 0};
        tabla[1]  = '{16'h1000, 4, 1, 4'hE, 0};
        tabla[2]  = '{16'h8000, 4, 1, 4'hD, 0};
        tabla[3]  = '{16'h0202, 4, 0, 4'hD, 4};
        tabla[4]  = '{16'h0040, 3, 1, 4'h6, 0};
        tabla[5]  = '{16'h2000, 4, 1, 4'h0, 0};
        tabla[6]  = '{16'h0003, 4, 0, 4'h0, 4};
        tabla[7]  = '{16'h0020, 2, 0, 4'h0, 0};
        tabla[8]  = '{16'h0400, 4, 1, 4'h9, 0};
        tabla[9]  = '{16'h0080, 4, 1, 4'hB, 0};
        tabla[10] = '{16'h0800, 4, 1, 4'hC, 0};

        // ---- reset state ----
        rst_n = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_cols_a", 32'(col_a), 32'hF);
        check("rst_cols_b", 32'(col_b), 32'hF);
        check("rst_code_a", 32'(code_a), 0);
        check("rst_valid_a", 32'(valid_a), 0);
        check("rst_held_a", 32'(held_a), 0);
        check("rst_multi_a", 32'(multi_a), 0);
        check("rst_code_b", 32'(code_b), 0);
        check("rst_valid_b", 32'(valid_b), 0);

        // ---- column rotation after release, no event on release ----
        rst_n = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            col_exp = 4'hF;
            col_exp[((n - 1) / 4) % 4] = 1'b0;
            check("col_rotation", 32'(col_a), 32'(col_exp));
            check("no_evt_release", 32'(valid_a), 0);
        end

        // ---- exact press latency, hold 5 scans, release ----
        wait_boundary();
        teclas = 16'h0001;
        cv_a = 0;
        for (int r = 1; r <= 129; r++) begin
            @(negedge clk);
            if (r <= 50) check("press_latency", 32'(valid_a), (r == 49) ? 1 : 0);
            else if (valid_a) cv_a++;
            if (r == 49) begin
                check("press_code", 32'(code_a), 32'h1);
                check("press_held", 32'(held_a), 1);
            end
            if (multi_a) cv_a++;
            if (r == 80) teclas = '0;
            if (r == 128) check("held_before_rel", 32'(held_a), 1);
            if (r == 129) check("held_after_rel", 32'(held_a), 0);
        end
        check("no_extra_evt", 32'(cv_a), 0);

        // ---- table of single presses, ghosts and short presses ----
        for (int i = 0; i < 11; i++) begin
            wait_boundary();
            teclas = tabla[i].teclas;
            cv_a = 0; cv_b = 0; cm = 0;
            for (int r = 1; r <= tabla[i].scans * 16 + 64; r++) begin
                @(negedge clk);
                if (valid_a) cv_a++;
                if (valid_b) cv_b++;
                if (multi_a) cm++;
                if (r == tabla[i].scans * 16) teclas = '0;
            end
            check($sformatf("tab%0d_valid_a", i), 32'(cv_a), 32'(tabla[i].n_valid));
            check($sformatf("tab%0d_valid_b", i), 32'(cv_b), 32'(tabla[i].n_valid));
            check($sformatf("tab%0d_code_a", i), 32'(code_a), 32'(tabla[i].code));
            check($sformatf("tab%0d_code_b", i), 32'(code_b), 32'(tabla[i].code));
            check($sformatf("tab%0d_multi", i), 32'(cm), 32'(tabla[i].n_multi));
            check($sformatf("tab%0d_held_end", i), 32'(held_a), 0);
        end

        // ---- bounce on row1/col2, then stable ----
        wait_boundary();
        cv_a = 0;
        for (int r = 1; r <= 176; r++) begin
            @(negedge clk);
            if (r < 97 && valid_a) cv_a++;
            if (r == 97) begin
                check("bounce_valid", 32'(valid_a), 1);
                check("bounce_code", 32'(code_a), 32'h6);
            end
            if (r > 97 && valid_a) cv_a++;
            if (r < 112)
                teclas = (((r >= 10) && (r < 20)) || ((r >= 30) && (r < 40)) || (r >= 48)) ? 16'h0040 : 16'h0000;
            else
                teclas = '0;
        end
        check("bounce_no_other", 32'(cv_a), 0);
        check("bounce_held_end", 32'(held_a), 0);

        // ---- auto-repeat on row2/col1, reset mid-hold ----
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_boundary();
        teclas = 16'h0200;
        cv_a = 0;
        for (int r = 1; r <= 196; r++) begin
            @(negedge clk);
            check("rep_pulse", 32'(valid_b), (r == 49 || r == 113 || r == 145 || r == 177) ? 1 : 0);
            if (valid_b) check("rep_code", 32'(code_b), 32'h8);
            if (valid_a) cv_a++;
            if (r == 192) check("rep_held", 32'(held_b), 1);
        end
        check("norep_count", 32'(cv_a), 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("midhold_rst_held", 32'(held_b), 0);
        check("midhold_rst_valid", 32'(valid_b), 0);
        check("midhold_rst_code", 32'(code_b), 0);
        check("midhold_rst_cols", 32'(col_b), 32'hF);
        teclas = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cv_a = 0; cv_b = 0;
        repeat (80) begin
            @(negedge clk);
            if (valid_a) cv_a++;
            if (valid_b) cv_b++;
        end
        check("post_rst_valid_b", 32'(cv_b), 0);
        check("post_rst_valid_a", 32'(cv_a), 0);
        check("post_rst_held_b", 32'(held_b), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "timeout");
    end

endmodule
